delay_calc: RTL and testbench

- Sequential beamforming delay calculator: computes the geometric distance from a transducer element at (x_i, z_i) to a focal point at (x_f, z_f), scales it to sample units and emits an 8-bit delay.
- Multi-cycle FSM: absolute differences, squares, sum, iterative integer square root, scale/saturate.
- Sits in the beamforming datapath feeding the per-channel delay lines; one calculation per start.

---
 rtl/delay_calc_pkg.sv | 35 +++
 rtl/delay_calc_isqrt.sv | 103 ++++++++++
 rtl/delay_calc.sv | 175 +++++++++++++++++
 tb/tb_delay_calc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/delay_calc_pkg.sv
// Shared types and widths for the delay_calc beamforming delay calculator.
// Optional build macro DELAY_CALC_ROUND_EN is consumed by delay_calc.sv.
package delay_calc_pkg;

  localparam int COORD_W    = 16;
  localparam int SQ_W       = 32;
  localparam int SUM_W      = 33;
  localparam int ROOT_W     = 17;
  localparam int OUT_W      = 8;
  localparam int SQRT_ITERS = 17;

  localparam logic [OUT_W-1:0] SAT_VAL = 8'd255;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DIFF   = 4'd1,
    ST_SQUARE = 4'd2,
    ST_SUM    = 4'd3,
    ST_SQRT   = 4'd4,
    ST_SCALE  = 4'd5,
    ST_DONE   = 4'd6
  } state_e;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

endpackage

// File: rtl/delay_calc_isqrt.sv
// Bit-serial restoring integer square root: 33-bit radicand, 17-bit root plus
// remainder, one result bit per clock; the start edge performs the first step.
module delay_calc_isqrt
  import delay_calc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [SUM_W-1:0]  i_radicand,
  output logic              o_busy,
  output logic              o_last,
  output logic              o_done,
  output logic [ROOT_W-1:0] o_root,
  output logic [ROOT_W:0]   o_rem
);

  localparam logic [4:0] ITER_LAST = 5'(SQRT_ITERS - 1);

  logic [2*ROOT_W-1:0] r_op;
  logic [ROOT_W:0]     r_rem;
  logic [ROOT_W-1:0]   r_root;
  logic [4:0]          r_cnt;
  logic                r_busy;
  logic                r_done;

  logic                w_load;
  logic                w_step;
  logic [2*ROOT_W-1:0] w_op;
  logic [ROOT_W:0]     w_rem_in;
  logic [ROOT_W-1:0]   w_root_in;
  logic [ROOT_W+2:0]   w_acc;
  logic [ROOT_W+2:0]   w_trial;
  logic                w_ge;
  logic [ROOT_W:0]     w_rem_nxt;
  logic [ROOT_W-1:0]   w_root_nxt;

  assign w_load = i_start & ~r_busy;
  assign w_step = w_load | r_busy;

  // One restoring step: bring down the next bit pair, try subtracting 4r+1.
  always_comb begin
    if (w_load) begin
      w_op      = {1'b0, i_radicand};
      w_rem_in  = {(ROOT_W+1){1'b0}};
      w_root_in = {ROOT_W{1'b0}};
    end else begin
      w_op      = r_op;
      w_rem_in  = r_rem;
      w_root_in = r_root;
    end
    w_acc   = {w_rem_in, w_op[2*ROOT_W-1:2*ROOT_W-2]};
    w_trial = {1'b0, w_root_in, 2'b01};
    w_ge    = (w_acc >= w_trial);
    if (w_ge) begin
      w_rem_nxt = (ROOT_W+1)'(w_acc - w_trial);
    end else begin
      w_rem_nxt = w_acc[ROOT_W:0];
    end
    w_root_nxt = {w_root_in[ROOT_W-2:0], w_ge};
  end

  // Iteration registers and busy/done handshake.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op   <= {(2*ROOT_W){1'b0}};
      r_rem  <= {(ROOT_W+1){1'b0}};
      r_root <= {ROOT_W{1'b0}};
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_step) begin
        r_op   <= {w_op[2*ROOT_W-3:0], 2'b00};
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
      end else begin
        r_op   <= r_op;
        r_rem  <= r_rem;
        r_root <= r_root;
      end
      if (w_load) begin
        r_busy <= 1'b1;
        r_cnt  <= 5'd1;
      end else if (r_busy && (r_cnt == ITER_LAST)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_cnt  <= 5'd0;
      end else if (r_busy) begin
        r_cnt  <= r_cnt + 5'd1;
      end else begin
        r_cnt  <= r_cnt;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_last = r_busy & (r_cnt == ITER_LAST);
  assign o_done = r_done;
  assign o_root = r_root;
  assign o_rem  = r_rem;

endmodule

// File: rtl/delay_calc.sv
// Beamforming delay: distance from element to focus, scaled and saturated to 8 bits.
// Build macro DELAY_CALC_ROUND_EN rounds the root to nearest instead of flooring.
module delay_calc
  import delay_calc_pkg::*;
#(
  parameter int SCALE_MUL   = 1,
  parameter int SCALE_SHIFT = 0
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] z_i,
  input  logic [COORD_W-1:0] x_f,
  input  logic [COORD_W-1:0] z_f,
  output logic [OUT_W-1:0]   delay_out,
  output logic               done,
  output logic [3:0]         debug_state
);

  localparam int PROD_W = ROOT_W + 8;
  localparam logic [PROD_W-1:0] MUL_C = PROD_W'(SCALE_MUL);

  state_e r_state;
  state_e w_state_nxt;

  logic [COORD_W-1:0] r_xi, r_zi, r_xf, r_zf;
  logic [COORD_W-1:0] r_dx, r_dz;
  logic [SQ_W-1:0]    r_dx2, r_dz2;
  logic [SUM_W-1:0]   r_d2;
  logic [OUT_W-1:0]   r_delay;
  logic               r_done;

  logic [SQ_W-1:0]    w_dx_ext, w_dz_ext;
  logic               w_sq_start, w_sq_busy, w_sq_last, w_sq_done;
  logic [ROOT_W-1:0]  w_sq_root;
  logic [ROOT_W:0]    w_sq_rem;
  logic               w_round_up;
  logic [ROOT_W-1:0]  w_root_adj;
  logic [PROD_W-1:0]  w_prod, w_scaled;
  logic [OUT_W-1:0]   w_sat;

  assign w_dx_ext   = {16'd0, r_dx};
  assign w_dz_ext   = {16'd0, r_dz};
  assign w_sq_start = (r_state == ST_SQRT) & ~w_sq_busy;

  delay_calc_isqrt u_isqrt (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (w_sq_start),
    .i_radicand (r_d2),
    .o_busy     (w_sq_busy),
    .o_last     (w_sq_last),
    .o_done     (w_sq_done),
    .o_root     (w_sq_root),
    .o_rem      (w_sq_rem)
  );

`ifdef DELAY_CALC_ROUND_EN
  assign w_round_up = (w_sq_rem > {1'b0, w_sq_root});
`else
  assign w_round_up = 1'b0 & (|w_sq_rem);
`endif

  // Scale the (optionally rounded) root and clamp to the 8-bit delay range.
  always_comb begin
    if (w_round_up) begin
      w_root_adj = w_sq_root + 17'd1;
    end else begin
      w_root_adj = w_sq_root;
    end
    w_prod   = {8'd0, w_root_adj} * MUL_C;
    w_scaled = w_prod >> SCALE_SHIFT;
    if (w_scaled > {17'd0, SAT_VAL}) begin
      w_sat = SAT_VAL;
    end else begin
      w_sat = w_scaled[OUT_W-1:0];
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_DIFF;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DIFF:   w_state_nxt = ST_SQUARE;
      ST_SQUARE: w_state_nxt = ST_SUM;
      ST_SUM:    w_state_nxt = ST_SQRT;
      ST_SQRT: begin
        if (w_sq_last) begin
          w_state_nxt = ST_SCALE;
        end else begin
          w_state_nxt = ST_SQRT;
        end
      end
      ST_SCALE:  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: each stage writes its result in the cycle its state is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xi    <= 16'd0;
      r_zi    <= 16'd0;
      r_xf    <= 16'd0;
      r_zf    <= 16'd0;
      r_dx    <= 16'd0;
      r_dz    <= 16'd0;
      r_dx2   <= 32'd0;
      r_dz2   <= 32'd0;
      r_d2    <= 33'd0;
      r_delay <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_xi <= x_i;
            r_zi <= z_i;
            r_xf <= x_f;
            r_zf <= z_f;
          end else begin
            r_xi <= r_xi;
          end
        end
        ST_DIFF: begin
          r_dx <= abs_diff(r_xi, r_xf);
          r_dz <= abs_diff(r_zi, r_zf);
        end
        ST_SQUARE: begin
          r_dx2 <= w_dx_ext * w_dx_ext;
          r_dz2 <= w_dz_ext * w_dz_ext;
        end
        ST_SUM: begin
          r_d2 <= {1'b0, r_dx2} + {1'b0, r_dz2};
        end
        ST_SCALE: begin
          if (w_sq_done) begin
            r_delay <= w_sat;
            r_done  <= 1'b1;
          end else begin
            r_delay <= r_delay;
          end
        end
        default: begin
          r_delay <= r_delay;
        end
      endcase
    end
  end

  assign delay_out   = r_delay;
  assign done        = r_done;
  assign debug_state = r_state;

endmodule

// File: tb/tb_delay_calc.sv
// Directed, table-driven bench for delay_calc (default and SCALE_MUL=3/SHIFT=1).
module tb_delay_calc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_i = 16'd0, z_i = 16'd0, x_f = 16'd0, z_f = 16'd0;
  logic [7:0]  delay_out, delay_out_s;
  logic        done, done_s;
  logic [3:0]  debug_state, debug_state_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_calc dut (
    .clk(clk), .reset(reset), .start(start),
    .x_i(x_i), .z_i(z_i), .x_f(x_f), .z_f(z_f),
    .delay_out(delay_out), .done(done), .debug_state(debug_state)
  );

  delay_calc #(.SCALE_MUL(3), .SCALE_SHIFT(1)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .x_i(x_i), .z_i(z_i), .x_f(x_f), .z_f(z_f),
    .delay_out(delay_out_s), .done(done_s), .debug_state(debug_state_s)
  );

  typedef struct {
    logic [15:0] xi, zi, xf, zf;
    int          exp_d;
    int          exp_s;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One calculation with a start pulse; optionally disturbs inputs/start mid-way.
  task automatic run_calc(input logic [15:0] xi, zi, xf, zf,
                          input int exp_d, exp_s, input bit disturb);
    int e;
    int k;
    @(negedge clk);
    x_i = xi; z_i = zi; x_f = xf; z_f = zf;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
    k = 0;
    while (k == 0 && e < 40) begin
      e++;
      @(posedge clk);
      #1;
      if (disturb && e == 5) begin
        x_i = 16'd0; z_i = 16'd0; x_f = 16'd1000; z_f = 16'd900;
        start = 1'b1;
      end
      if (disturb && e == 7) start = 1'b0;
      if (done) k = e;
    end
    check("done_latency", k, 21);
    check("done_s_sync", int'(done_s), 1);
    check("delay_out", int'(delay_out), exp_d);
    check("delay_out_scaled", int'(delay_out_s), exp_s);
    check("state_done", int'(debug_state), 6);
    @(posedge clk);
    #1;
    check("done_one_cycle", int'(done), 0);
    check("state_idle_after", int'(debug_state), 0);
  endtask

  initial begin
    int pulses, p1, p2, stray;

    vecs[0] = '{16'd12,  16'd12,  16'd6,     16'd4,  10,  15};
    vecs[1] = '{16'd100, 16'd50,  16'd100,   16'd50, 0,   0};
`ifdef DELAY_CALC_ROUND_EN
    vecs[2] = '{16'd10,  16'd20,  16'd12,    16'd17, 4,   6};
`else
    vecs[2] = '{16'd10,  16'd20,  16'd12,    16'd17, 3,   4};
`endif
    vecs[3] = '{16'd7,   16'd0,   16'd6,     16'd2,  2,   3};
    vecs[4] = '{16'd0,   16'd65535, 16'd65535, 16'd0, 255, 255};
    vecs[5] = '{16'd0,   16'd160, 16'd120,   16'd0,  200, 255};

    // Reset for one cycle, then check the idle outputs.
    @(posedge clk);
    #1;
    check("rst_state_during", int'(debug_state), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_delay_out", int'(delay_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_debug_state", int'(debug_state), 0);

    foreach (vecs[i]) begin
      run_calc(vecs[i].xi, vecs[i].zi, vecs[i].xf, vecs[i].zf,
               vecs[i].exp_d, vecs[i].exp_s, 1'b0);
    end

    // Start held high: back-to-back calculations every 23 cycles.
    @(negedge clk);
    x_i = 16'd12; z_i = 16'd12; x_f = 16'd6; z_f = 16'd4;
    start = 1'b1;
    @(posedge clk);
    pulses = 0; p1 = 0; p2 = 0;
    for (int e = 1; e <= 46; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) p1 = e;
        if (pulses == 2) p2 = e;
      end
      if (e == 44) start = 1'b0;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_first", p1, 21);
    check("b2b_second", p2, 44);
    check("b2b_delay", int'(delay_out), 10);
    check("b2b_idle", int'(debug_state), 0);

    // Inputs changed and start pulsed mid-calculation: ignored.
    run_calc(16'd12, 16'd12, 16'd6, 16'd4, 10, 15, 1'b1);

    // Reset during SQRT aborts immediately with no result.
    @(negedge clk);
    x_i = 16'd0; z_i = 16'd160; x_f = 16'd120; z_f = 16'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 10; e++) @(posedge clk);
    #1;
    check("mid_state_sqrt", int'(debug_state), 4);
    reset = 1'b1;
    #1;
    check("abort_state", int'(debug_state), 0);
    check("abort_delay", int'(delay_out), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    check("abort_no_done", stray, 0);
    check("abort_delay_held", int'(delay_out), 0);
    run_calc(16'd0, 16'd160, 16'd120, 16'd0, 200, 255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
